// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray-code helpers and width limits
package gray_pkg;

  localparam int MAX_WIDTH = 32;

  function automatic logic [MAX_WIDTH-1:0] bin2gray(
    input logic [MAX_WIDTH-1:0] value,
    input int                   width
  );
    logic [MAX_WIDTH-1:0] mask;
    if (width >= MAX_WIDTH) begin
      mask = '1;
    end else begin
      mask = (MAX_WIDTH'(1) << width) - MAX_WIDTH'(1);
    end
    return (value ^ (value >> 1)) & mask;
  endfunction

  // Prefix XOR from the MSB down, restricted to the low `width` bits.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(
    input logic [MAX_WIDTH-1:0] value,
    input int                   width
  );
    logic [MAX_WIDTH-1:0] result;
    logic                 acc;
    result = '0;
    acc    = 1'b0;
    for (int i = MAX_WIDTH - 1; i >= 0; i--) begin
      if (i < width) begin
        acc       = acc ^ value[i];
        result[i] = acc;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// rtl/gray_to_bin.sv - combinational Gray-to-binary prefix-XOR decoder
module gray_to_bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // Each binary bit is the parity of the Gray bits at and above it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_counter.sv
// rtl/gray_counter.sv - registered up/down Gray counter with a Gray decode channel
module gray_counter
  import gray_pkg::*;
#(
  parameter int          WIDTH       = 4,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] gray_q,
  output logic             wrap,
  input  logic             conv_valid_in,
  input  logic [WIDTH-1:0] gray_in,
  output logic             conv_valid_out,
  output logic [WIDTH-1:0] conv_bin_out
);

  localparam logic [WIDTH-1:0] RESET_BIN  = RESET_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RESET_GRAY = RESET_BIN ^ (RESET_BIN >> 1);

  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_d;
  logic             wrap_d;
  logic             wrap_q;
  logic [WIDTH-1:0] conv_dec;
  logic [WIDTH-1:0] conv_bin_d;
  logic [WIDTH-1:0] conv_bin_q;
  logic             conv_valid_d;
  logic             conv_valid_q;

  // Gray is encoded from the next binary value so both registers move together.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      if (up) begin
        bin_d  = bin_q + WIDTH'(1);
        wrap_d = &bin_q;
      end else begin
        bin_d  = bin_q - WIDTH'(1);
        wrap_d = ~|bin_q;
      end
    end
    gray_d = WIDTH'(bin2gray(MAX_WIDTH'(bin_d), WIDTH));
  end

  gray_to_bin #(
    .WIDTH (WIDTH)
  ) u_gray_to_bin (
    .gray_i (gray_in),
    .bin_o  (conv_dec)
  );

  always_comb begin
    conv_valid_d = conv_valid_in;
    conv_bin_d   = conv_bin_q;
    if (conv_valid_in) begin
      conv_bin_d = conv_dec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q        <= RESET_BIN;
      gray_q       <= RESET_GRAY;
      wrap_q       <= 1'b0;
      conv_valid_q <= 1'b0;
      conv_bin_q   <= '0;
    end else begin
      bin_q        <= bin_d;
      gray_q       <= gray_d;
      wrap_q       <= wrap_d;
      conv_valid_q <= conv_valid_d;
      conv_bin_q   <= conv_bin_d;
    end
  end

  assign wrap           = wrap_q;
  assign conv_valid_out = conv_valid_q;
  assign conv_bin_out   = conv_bin_q;

endmodule

// File: tb/tb_gray_counter.sv
// tb/tb_gray_counter.sv - scoreboard bench for gray_counter (4-bit and 8-bit instances)
module tb_gray_counter;

  typedef struct {
    logic [3:0] bin;
    logic [3:0] gray;
    logic       wrap;
    logic       cvo;
    logic       cchk;
    logic [3:0] cbin;
    logic       onebit;
    string      name;
  } cnt_rec_t;

  logic       clk = 1'b0;
  logic       rst4, en4, up4, load4, cvi4;
  logic [3:0] lb4, gi4;
  logic [3:0] bin4, gray4, cbo4;
  logic       wrap4, cvo4;

  logic       rst8, en8, up8, load8, cvi8;
  logic [7:0] lb8, gi8;
  logic [7:0] bin8, gray8, cbo8;
  logic       wrap8, cvo8;

  int n_checks = 0;
  int n_errors = 0;

  cnt_rec_t   cnt_q[$];
  logic [3:0] conv_q[$];
  cnt_rec_t   rec;
  logic [3:0] cexp_m;
  logic [3:0] prev_gray = 4'h0;
  logic [3:0] gtab [16];

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(4), .RESET_VALUE(0)) dut4 (
    .clk(clk), .rst(rst4), .en(en4), .up(up4), .load(load4), .load_bin(lb4),
    .bin_q(bin4), .gray_q(gray4), .wrap(wrap4),
    .conv_valid_in(cvi4), .gray_in(gi4),
    .conv_valid_out(cvo4), .conv_bin_out(cbo4)
  );

  gray_counter #(.WIDTH(8), .RESET_VALUE(32'h80)) dut8 (
    .clk(clk), .rst(rst8), .en(en8), .up(up8), .load(load8), .load_bin(lb8),
    .bin_q(bin8), .gray_q(gray8), .wrap(wrap8),
    .conv_valid_in(cvi8), .gray_in(gi8),
    .conv_valid_out(cvo8), .conv_bin_out(cbo8)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step(
    input logic l, input logic [3:0] lb, input logic e, input logic u,
    input logic cv, input logic [3:0] gi, input logic [3:0] cexp,
    input logic [3:0] eb, input logic [3:0] eg, input logic ew, input logic ecvo,
    input logic ecchk, input logic [3:0] ecb, input logic ob, input string nm
  );
    cnt_rec_t r;
    @(negedge clk);
    load4 = l; lb4 = lb; en4 = e; up4 = u; cvi4 = cv; gi4 = gi;
    r.bin = eb; r.gray = eg; r.wrap = ew; r.cvo = ecvo;
    r.cchk = ecchk; r.cbin = ecb; r.onebit = ob; r.name = nm;
    cnt_q.push_back(r);
    if (cv) conv_q.push_back(cexp);
  endtask

  // Monitor: compares each registered result 2 time units after the edge.
  always @(posedge clk) begin
    #2;
    if (cnt_q.size() > 0) begin
      rec = cnt_q.pop_front();
      chk({rec.name, ".bin"},  32'(bin4),  32'(rec.bin));
      chk({rec.name, ".gray"}, 32'(gray4), 32'(rec.gray));
      chk({rec.name, ".wrap"}, 32'(wrap4), 32'(rec.wrap));
      chk({rec.name, ".cvo"},  32'(cvo4),  32'(rec.cvo));
      if (rec.cchk) chk({rec.name, ".cbin_hold"}, 32'(cbo4), 32'(rec.cbin));
      if (rec.onebit) chk({rec.name, ".gray_onebit"}, 32'($countones(prev_gray ^ gray4)), 32'd1);
      prev_gray = gray4;
    end
    if (cvo4) begin
      if (conv_q.size() > 0) begin
        cexp_m = conv_q.pop_front();
        chk("conv.bin", 32'(cbo4), 32'(cexp_m));
      end else begin
        chk("conv.unexpected_valid", 32'(cvo4), 32'd0);
      end
    end
  end

  initial begin
    gtab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
             4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    rst4 = 1'b0; en4 = 1'b0; up4 = 1'b0; load4 = 1'b0; cvi4 = 1'b0; lb4 = 4'h0; gi4 = 4'h0;
    rst8 = 1'b0; en8 = 1'b0; up8 = 1'b0; load8 = 1'b0; cvi8 = 1'b0; lb8 = 8'h0; gi8 = 8'h0;
    #1;
    rst4 = 1'b1; rst8 = 1'b1;
    #1;
    chk("reset.bin",  32'(bin4),  32'h0);
    chk("reset.gray", 32'(gray4), 32'h0);
    chk("reset.wrap", 32'(wrap4), 32'h0);
    chk("reset.cvo",  32'(cvo4),  32'h0);
    chk("reset.cbin", 32'(cbo4),  32'h0);
    chk("reset8.bin", 32'(bin8),  32'h80);
    chk("reset8.gray", 32'(gray8), 32'hC0);
    repeat (3) @(posedge clk);
    #2;
    chk("reset_held.bin", 32'(bin4), 32'h0);
    @(negedge clk);
    rst4 = 1'b0; rst8 = 1'b0;

    for (int k = 1; k <= 16; k++) begin
      step(0, 4'h0, 1, 1, 0, 4'h0, 4'h0, 4'(k % 16), gtab[k % 16], (k == 16), 0, 0, 4'h0, 1, "sweep");
    end
    step(0, 4'h0, 0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, "hold");

    step(1, 4'h0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, "load0");
    step(0, 4'h0, 1, 0, 0, 4'h0, 4'h0, 4'hF, 4'h8, 1, 0, 0, 4'h0, 1, "down_wrap");
    step(0, 4'h0, 1, 0, 0, 4'h0, 4'h0, 4'hE, 4'h9, 0, 0, 0, 4'h0, 1, "down14");
    step(0, 4'h0, 1, 1, 0, 4'h0, 4'h0, 4'hF, 4'h8, 0, 0, 0, 4'h0, 1, "dir_up");
    step(0, 4'h0, 1, 0, 0, 4'h0, 4'h0, 4'hE, 4'h9, 0, 0, 0, 4'h0, 1, "dir_down");

    step(1, 4'h7, 0, 0, 0, 4'h0, 4'h0, 4'h7, 4'h4, 0, 0, 0, 4'h0, 0, "load7");
    step(1, 4'hC, 1, 1, 0, 4'h0, 4'h0, 4'hC, 4'hA, 0, 0, 0, 4'h0, 0, "load_prio");

    step(1, 4'hF, 0, 0, 0, 4'h0, 4'h0, 4'hF, 4'h8, 0, 0, 0, 4'h0, 0, "loadF_a");
    step(0, 4'h0, 1, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0, 4'h0, 0, "wrap_a");
    step(1, 4'hF, 0, 0, 0, 4'h0, 4'h0, 4'hF, 4'h8, 0, 0, 0, 4'h0, 0, "loadF_b");
    step(0, 4'h0, 1, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0, 4'h0, 0, "wrap_b");
    step(0, 4'h0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, "post_wrap");

    step(0, 4'h0, 0, 0, 1, 4'hD, 4'h9, 4'h0, 4'h0, 0, 1, 0, 4'h0, 0, "conv_d");
    step(0, 4'h0, 0, 0, 1, 4'h6, 4'h4, 4'h0, 4'h0, 0, 1, 0, 4'h0, 0, "conv_6");
    step(0, 4'h0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 1, 4'h4, 0, "conv_drop");
    step(0, 4'h0, 0, 0, 0, 4'h3, 4'h0, 4'h0, 4'h0, 0, 0, 1, 4'h4, 0, "conv_hold");
    step(0, 4'h0, 1, 1, 1, 4'h8, 4'hF, 4'h1, 4'h1, 0, 1, 0, 4'h0, 1, "conv_cnt_8");
    step(0, 4'h0, 1, 1, 1, 4'h0, 4'h0, 4'h2, 4'h3, 0, 1, 0, 4'h0, 1, "conv_cnt_0");
    step(0, 4'h0, 0, 0, 0, 4'h0, 4'h0, 4'h2, 4'h3, 0, 0, 1, 4'h0, 0, "conv_end");
    @(negedge clk);
    en4 = 1'b0; load4 = 1'b0; cvi4 = 1'b0;
    repeat (2) @(negedge clk);
    chk("scoreboard.cnt_drained",  32'(cnt_q.size()),  32'd0);
    chk("scoreboard.conv_drained", 32'(conv_q.size()), 32'd0);

    @(negedge clk);
    load8 = 1'b1; lb8 = 8'h3F;
    @(negedge clk);
    load8 = 1'b0; en8 = 1'b1; up8 = 1'b1; cvi8 = 1'b1; gi8 = 8'h3C;
    @(posedge clk);
    #2;
    chk("w8.pre_bin",  32'(bin8),  32'h40);
    chk("w8.pre_gray", 32'(gray8), 32'h60);
    chk("w8.pre_cvo",  32'(cvo8),  32'h1);
    chk("w8.pre_cbin", 32'(cbo8),  32'h28);
    #1;
    rst8 = 1'b1;
    #1;
    chk("w8.rst_bin",  32'(bin8),  32'h80);
    chk("w8.rst_gray", 32'(gray8), 32'hC0);
    chk("w8.rst_wrap", 32'(wrap8), 32'h0);
    chk("w8.rst_cvo",  32'(cvo8),  32'h0);
    chk("w8.rst_cbin", 32'(cbo8),  32'h0);
    @(negedge clk);
    rst8 = 1'b0; cvi8 = 1'b0;
    @(posedge clk);
    #2;
    chk("w8.first_bin",  32'(bin8),  32'h81);
    chk("w8.first_gray", 32'(gray8), 32'hC1);
    chk("w8.first_cvo",  32'(cvo8),  32'h0);
    en8 = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
# gray_counter

Parametrised registered Gray-code counter with an independent Gray-to-binary conversion channel. It is the clocked, width-generic successor to the 4-bit combinational binary-to-Gray converter. It provides an up/down counter that keeps its binary and Gray forms in lockstep, plus a one-cycle-latency decoder for Gray values arriving from elsewhere. It is intended for pointer generation and pointer decoding in clock-domain-crossing FIFOs and for position encoders.

## Interface
- WIDTH, 4, counter and conversion width in bits; legal range 2..32
- RESET_VALUE, 0, binary value loaded on reset; must be < 2^WIDTH
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  count enable; one step per cycle while high
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1
- load  input  1  synchronous load; priority over en
- load_bin  input  WIDTH  binary value applied when load=1
- bin_q  output  WIDTH  registered binary count
- gray_q  output  WIDTH  registered Gray code of bin_q, gray_q = bin_q ^ (bin_q >> 1)
- wrap  output  1  one-cycle pulse on the step that wraps around
- conv_valid_in  input  1  gray_in is valid this cycle
- gray_in  input  WIDTH  Gray value to decode
- conv_valid_out  output  1  conv_bin_out is valid
- conv_bin_out  output  WIDTH  registered binary decode of the captured gray_in

## Operation
- Reset (rst=1, asynchronous, immediate) sets the outputs as follows:
  - bin_q = RESET_VALUE
  - gray_q = RESET_VALUE ^ (RESET_VALUE >> 1)
  - wrap = 0, conv_valid_out = 0, conv_bin_out = 0
- Counter update priority per clk edge is load > en > hold:
  - load=1: bin_q <= load_bin, gray_q <= Gray(load_bin), wrap <= 0. en and up are ignored.
  - en=1, up=1: bin_q <= bin_q + 1 mod 2^WIDTH. wrap <= 1 iff the old bin_q was all ones.
  - en=1, up=0: bin_q <= bin_q − 1 mod 2^WIDTH. wrap <= 1 iff the old bin_q was 0.
  - Otherwise the count holds and wrap <= 0.
- Encoding rules:
  - gray_q is always computed from the next binary value and registered in the same edge as bin_q. It is never derived combinationally from bin_q at the output.
  - Consecutive gray_q values on any count step, including wrap, differ in exactly one bit.
  - A load may change any number of bits.
- Direction change between consecutive enabled cycles is legal and takes effect immediately. For example 5 up → 6, then down → 5.
- Conversion channel (independent of the counter, may run in the same cycle):
  - conv_bin_out[WIDTH-1] = gray_in[WIDTH-1]
  - conv_bin_out[i] = conv_bin_out[i+1] ^ gray_in[i]
  - Captured when conv_valid_in=1. conv_valid_out follows conv_valid_in one cycle later.
  - When conv_valid_in=0, conv_bin_out holds its last value and conv_valid_out drops to 0.
- The block has no backpressure. The conversion channel accepts one value per cycle at full throughput.

## Timing
- All outputs are registered. Latency from any input to its effect is 1 clk edge.
- wrap is high for exactly the one cycle following the wrapping edge. Back-to-back wraps are possible for WIDTH ≥ 2 only under repeated loads, since continuous counting wraps once every 2^WIDTH cycles.
- rst asserted mid-count or mid-conversion clears the state immediately without waiting for clk. An in-flight conversion is dropped (conv_valid_out=0).
- On release of rst, the first active edge with en=1 steps from RESET_VALUE.

## Structure
- Shared package `gray_pkg` holds:
  - MAX_WIDTH = 32
  - function bin2gray(value, width), which returns value ^ (value >> 1) masked to width
  - function gray2bin(value, width), a prefix-XOR from the MSB
- Sub-module `gray_to_bin` (parameter WIDTH): purely combinational prefix-XOR decoder.
  - Instantiated once in the conversion channel.
  - Reusable by FIFO pointer synchronisers.
- Counter next-state logic and the output registers live in `gray_counter` itself.

## Test plan
- Reset: WIDTH=4, RESET_VALUE=0, hold rst for 3 cycles → bin_q=0, gray_q=0000, wrap=0, conv_valid_out=0, with no clk edge required.
- Full up sweep: en=1, up=1 for 16 cycles → gray_q steps 0000,0001,0011,0010,0110,…,1000,0000. Every step differs in exactly one bit. wrap=1 only in the cycle after the 15→0 step.
- Down with wrap: load 0, then en=1, up=0 → bin_q=15, gray_q=1000, wrap=1 for one cycle; the next step gives bin_q=14, gray_q=1001, wrap=0.
- Load priority: bin_q=7, load=1 with load_bin=12, en=1, up=1 in the same cycle → bin_q=12, gray_q=1010, wrap=0.
- Conversion: conv_valid_in=1 with gray_in=1101, then 0110, then conv_valid_in=0 → conv_bin_out=9 then 4, conv_valid_out high for exactly 2 cycles, conv_bin_out holds 4.
- Async reset mid-operation: WIDTH=8, RESET_VALUE=0x80, counting up at 0x3F with a conversion in flight; assert rst between edges → bin_q=0x80, gray_q=0xC0, conv_valid_out=0 immediately.
